// File: rtl/iter_alu_hilo_pkg.sv
// Shared constants for the iterative HI/LO ALU: MIPS funct codes, the
// multiply/divide sequencer state encoding and operation select.
package iter_alu_hilo_pkg;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_op_e;

endpackage

// File: rtl/iter_alu_hilo_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// cycle. hi/lo expose the post-step values so the final step lands in the
// caller's registers on the same edge that done is high.
module seq_muldiv
  import iter_alu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output md_state_e        state_dbg
);

  localparam int SHW = $clog2(WIDTH);

  md_state_e        r_state;
  md_op_e           r_op;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic             w_last;

  // Multiply keeps {hi,lo} as the partial product with the multiplier in lo;
  // divide keeps the partial remainder in hi and shifts the quotient into lo.
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_shift  = {r_hi, r_lo[WIDTH-1]};
    w_borrow = (w_shift < {1'b0, r_b});
    w_diff   = w_shift[WIDTH-1:0] - r_b;
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_op == MD_MUL) begin
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end else if (w_borrow) begin
      w_hi_nxt = w_shift[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
    end else begin
      w_hi_nxt = w_diff;
      w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
    end
  end

  assign w_last    = (r_cnt == SHW'(WIDTH - 1));
  assign busy      = (r_state == MD_RUN);
  assign done      = (r_state == MD_RUN) && w_last;
  assign hi        = w_hi_nxt;
  assign lo        = w_lo_nxt;
  assign state_dbg = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_op    <= MD_MUL;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
    end else begin
      case (r_state)
        MD_IDLE, MD_DONE: begin
          if (start) begin
            r_state <= MD_RUN;
            r_op    <= op;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= (op == MD_MUL) ? b : a;
            r_b     <= (op == MD_MUL) ? a : b;
          end else begin
            r_state <= MD_IDLE;
          end
        end
        MD_RUN: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= MD_DONE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/iter_alu_hilo.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus iterative
// MULTU/DIVU into HI/LO. Handshake: an op is accepted on a rising clk edge
// where start=1 and ready=1; start while ready=0 is dropped, not queued.
// Each accepted op yields exactly one result_valid pulse (unless reset aborts it).
module iter_alu_hilo
  import iter_alu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             illegal_op,
  output md_state_e        dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_result;
  logic             r_valid;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;
  logic             r_ill;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_div_zero;
  logic             w_md_start;
  md_op_e           w_md_op;
  logic             w_md_busy;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_lo;
  logic             w_slt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ill;

  assign ready      = ~w_md_busy;
  assign w_accept   = start & ready;
  assign w_is_mul   = (funct == FN_MULTU);
  assign w_is_div   = (funct == FN_DIVU);
  assign w_div_zero = w_is_div && (dataB == '0);
  assign w_md_start = w_accept & (w_is_mul | (w_is_div & ~w_div_zero));
  assign w_md_op    = w_is_div ? MD_DIV : MD_MUL;
  assign w_slt      = ($signed(dataA) < $signed(dataB));

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (w_md_start),
    .op        (w_md_op),
    .a         (dataA),
    .b         (dataB),
    .busy      (w_md_busy),
    .done      (w_md_done),
    .hi        (w_md_hi),
    .lo        (w_md_lo),
    .state_dbg (dbg_state)
  );

  always_comb begin
    w_alu_res = '0;
    w_alu_ill = 1'b0;
    case (funct)
      FN_AND:   w_alu_res = dataA & dataB;
      FN_OR:    w_alu_res = dataA | dataB;
      FN_ADD:   w_alu_res = dataA + dataB;
      FN_SUB:   w_alu_res = dataA - dataB;
      FN_SLT:   w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
      FN_SLL:   w_alu_res = dataA << dataB[SHW-1:0];
      FN_SRL:   w_alu_res = dataA >> dataB[SHW-1:0];
      FN_MFHI:  w_alu_res = r_hi;
      FN_MFLO:  w_alu_res = r_lo;
      FN_MULTU, FN_DIVU: w_alu_res = '0;
      default:  w_alu_ill = 1'b1;
    endcase
  end

  // Sequencer completion only happens while ready=0, so it never collides
  // with a single-cycle accept on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_valid  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_dbz   <= 1'b0;
      r_ill   <= 1'b0;
      if (w_md_done) begin
        r_hi     <= w_md_hi;
        r_lo     <= w_md_lo;
        r_result <= w_md_lo;
        r_valid  <= 1'b1;
      end else if (w_accept && !w_md_start) begin
        r_valid <= 1'b1;
        if (w_div_zero) begin
          r_hi     <= dataA;
          r_lo     <= '1;
          r_result <= '1;
          r_dbz    <= 1'b1;
        end else begin
          r_result <= w_alu_res;
          r_ill    <= w_alu_ill;
        end
      end
    end
  end

  assign result       = r_result;
  assign result_valid = r_valid;
  assign hi           = r_hi;
  assign lo           = r_lo;
  assign div_by_zero  = r_dbz;
  assign illegal_op   = r_ill;

endmodule

// File: tb/tb_iter_alu_hilo.sv
// Bench for iter_alu_hilo: 32-bit and 8-bit instances, directed cases and
// randomized ops checked against an arithmetic reference model.
module tb_iter_alu_hilo;
  import iter_alu_hilo_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        s32_start = 1'b0, s8_start = 1'b0;
  logic [5:0]  s32_funct = '0, s8_funct = '0;
  logic [31:0] s32_a = '0, s32_b = '0;
  logic [7:0]  s8_a = '0, s8_b = '0;
  logic        s32_ready, s32_valid, s32_dbz, s32_ill;
  logic        s8_ready, s8_valid, s8_dbz, s8_ill;
  logic [31:0] s32_result, s32_hi, s32_lo;
  logic [7:0]  s8_result, s8_hi, s8_lo;
  md_state_e   s32_dbg, s8_dbg;

  iter_alu_hilo #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(s32_start), .funct(s32_funct),
    .dataA(s32_a), .dataB(s32_b), .ready(s32_ready), .result(s32_result),
    .result_valid(s32_valid), .hi(s32_hi), .lo(s32_lo),
    .div_by_zero(s32_dbz), .illegal_op(s32_ill), .dbg_state(s32_dbg)
  );

  iter_alu_hilo #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8_start), .funct(s8_funct),
    .dataA(s8_a), .dataB(s8_b), .ready(s8_ready), .result(s8_result),
    .result_valid(s8_valid), .hi(s8_hi), .lo(s8_lo),
    .div_by_zero(s8_dbz), .illegal_op(s8_ill), .dbg_state(s8_dbg)
  );

  int n_checks = 0;
  int n_pass = 0;
  longint unsigned m_hi32 = 0, m_lo32 = 0, m_hi8 = 0, m_lo8 = 0;

  // Reference model: plain arithmetic on 64-bit values, masked to w bits.
  task automatic ref_model(input int w, input logic [5:0] f,
                           input longint unsigned a, input longint unsigned b,
                           inout longint unsigned hi, inout longint unsigned lo,
                           output longint unsigned res, output bit ill,
                           output bit dbz, output bit mc);
    longint unsigned m, p, wu;
    longint sa, sb;
    m = (64'd1 << w) - 64'd1;
    wu = longint'(w);
    res = 0; ill = 0; dbz = 0; mc = 0;
    sa = ((a >> (w - 1)) & 1) != 0 ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb = ((b >> (w - 1)) & 1) != 0 ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    case (f)
      FN_AND:  res = a & b;
      FN_OR:   res = a | b;
      FN_ADD:  res = (a + b) & m;
      FN_SUB:  res = (a - b) & m;
      FN_SLT:  res = (sa < sb) ? 1 : 0;
      FN_SLL:  res = (a << (b % wu)) & m;
      FN_SRL:  res = a >> (b % wu);
      FN_MFHI: res = hi;
      FN_MFLO: res = lo;
      FN_MULTU: begin
        p = a * b; hi = p >> w; lo = p & m; res = lo; mc = 1;
      end
      FN_DIVU: begin
        if (b == 0) begin
          hi = a; lo = m; res = m; dbz = 1;
        end else begin
          hi = a % b; lo = a / b; res = lo; mc = 1;
        end
      end
      default: ill = 1;
    endcase
  endtask

  // Issues one op on the chosen instance, waits (bounded) for result_valid,
  // and returns observed and model-expected values.
  task automatic run_op(input bit n8, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [31:0] h,
                        output logic [31:0] l, output logic dz, output logic il,
                        output int lat, output logic [31:0] er,
                        output logic [31:0] eh, output logic [31:0] el,
                        output bit edz, output bit eil, output bit emc);
    longint unsigned am, bm, mh, ml, mr;
    logic got;
    am = n8 ? longint'(a[7:0]) : longint'(a);
    bm = n8 ? longint'(b[7:0]) : longint'(b);
    mh = n8 ? m_hi8 : m_hi32;
    ml = n8 ? m_lo8 : m_lo32;
    ref_model(n8 ? 8 : 32, f, am, bm, mh, ml, mr, eil, edz, emc);
    if (n8) begin m_hi8 = mh; m_lo8 = ml; end
    else begin m_hi32 = mh; m_lo32 = ml; end
    er = mr[31:0]; eh = mh[31:0]; el = ml[31:0];
    @(negedge clk);
    if (n8) begin s8_start = 1; s8_funct = f; s8_a = a[7:0]; s8_b = b[7:0]; end
    else begin s32_start = 1; s32_funct = f; s32_a = a; s32_b = b; end
    lat = 0;
    got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      s32_start = 0; s8_start = 0;
      lat++;
      got = n8 ? s8_valid : s32_valid;
    end
    r  = n8 ? {24'h0, s8_result} : s32_result;
    h  = n8 ? {24'h0, s8_hi} : s32_hi;
    l  = n8 ? {24'h0, s8_lo} : s32_lo;
    dz = n8 ? s8_dbz : s32_dbz;
    il = n8 ? s8_ill : s32_ill;
    if (!got) begin
      n_checks++;
      $display("FAIL timeout funct=%0d w=%0d no result_valid after %0d cycles", f, n8 ? 8 : 32, lat);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    n_checks++; if ({s32_ready, s32_valid, s32_dbz, s32_ill} !== 4'b1000) $display("FAIL reset_flags32 got %b exp 1000", {s32_ready, s32_valid, s32_dbz, s32_ill}); else n_pass++;
    n_checks++; if ({s32_result, s32_hi, s32_lo} !== 96'h0) $display("FAIL reset_regs32 got %h exp 0", {s32_result, s32_hi, s32_lo}); else n_pass++;
    n_checks++; if (s32_dbg !== MD_IDLE) $display("FAIL reset_state got %0d exp %0d", s32_dbg, MD_IDLE); else n_pass++;
    n_checks++; if ({s8_ready, s8_valid, s8_result, s8_hi, s8_lo} !== {2'b10, 24'h0}) $display("FAIL reset8 got %h", {s8_ready, s8_valid, s8_result, s8_hi, s8_lo}); else n_pass++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    s32_start = 1; s32_funct = FN_ADD; s32_a = 32'h7FFF_FFFF; s32_b = 32'h1;
    @(negedge clk);
    n_checks++; if ({s32_valid, s32_result} !== {1'b1, 32'h8000_0000}) $display("FAIL add_ovf got v=%b r=%h exp v=1 r=80000000", s32_valid, s32_result); else n_pass++;
    n_checks++; if (s32_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", s32_ready); else n_pass++;
    s32_funct = FN_SUB; s32_a = 32'd5; s32_b = 32'd7;
    @(negedge clk);
    s32_start = 0;
    n_checks++; if ({s32_valid, s32_result} !== {1'b1, 32'hFFFF_FFFE}) $display("FAIL sub_b2b got v=%b r=%h exp v=1 r=fffffffe", s32_valid, s32_result); else n_pass++;
    @(negedge clk);
    n_checks++; if (s32_valid !== 1'b0) $display("FAIL valid_single_pulse got %b exp 0", s32_valid); else n_pass++;
  endtask

  task automatic test_single_ops;
    logic [31:0] r, h, l, er, eh, el;
    logic dz, il;
    bit edz, eil, emc;
    int lat;
    run_op(0, FN_SLT, 32'hFFFF_FFFF, 32'd1, r, h, l, dz, il, lat, er, eh, el, edz, eil, emc);
    n_checks++; if (r !== 32'd1 || lat != 1) $display("FAIL slt_neg got r=%h lat=%0d exp r=1 lat=1", r, lat); else n_pass++;
    run_op(0, FN_SLL, 32'd1, 32'd31, r, h, l, dz, il, lat, er, eh, el, edz, eil, emc);
    n_checks++; if (r !== 32'h8000_0000) $display("FAIL sll31 got %h exp 80000000", r); else n_pass++;
    run_op(0, FN_SRL, 32'h8000_0000, 32'd31, r, h, l, dz, il, lat, er, eh, el, edz, eil, emc);
    n_checks++; if (r !== 32'd1) $display("FAIL srl31 got %h exp 1", r); else n_pass++;
    run_op(0, 6'd63, 32'h1234, 32'h5678, r, h, l, dz, il, lat, er, eh, el, edz, eil, emc);
    n_checks++; if ({r, il, dz} !== {32'h0, 1'b1, 1'b0}) $display("FAIL illegal got r=%h il=%b dz=%b exp r=0 il=1 dz=0", r, il, dz); else n_pass++;
    n_checks++; if ({h, l} !== {eh, el}) $display("FAIL illegal_hilo got %h exp %h", {h, l}, {eh, el}); else n_pass++;
  endtask

  task automatic test_divu;
    logic [31:0] r, h, l, er, eh, el;
    logic dz, il, got;
    bit edz, eil, emc;
    int lat, rdy_low, run_seen;
    longint unsigned mr;
    ref_model(32, FN_DIVU, 100, 7, m_hi32, m_lo32, mr, eil, edz, emc);
    @(negedge clk);
    s32_start = 1; s32_funct = FN_DIVU; s32_a = 32'd100; s32_b = 32'd7;
    lat = 0; rdy_low = 0; run_seen = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      s32_start = 0;
      lat++;
      got = s32_valid;
      if (!s32_ready) rdy_low++;
      if (lat == 5 && s32_dbg == MD_RUN) run_seen = 1;
    end
    n_checks++; if (lat != 33) $display("FAIL divu_latency got %0d exp 33", lat); else n_pass++;
    n_checks++; if (rdy_low != 32) $display("FAIL divu_ready_low got %0d exp 32", rdy_low); else n_pass++;
    n_checks++; if (run_seen != 1) $display("FAIL divu_run_state got %0d exp 1", run_seen); else n_pass++;
    n_checks++; if ({s32_result, s32_lo, s32_hi, s32_ready} !== {32'd14, 32'd14, 32'd2, 1'b1}) $display("FAIL divu_100_7 got r=%0d lo=%0d hi=%0d rdy=%b exp 14 14 2 1", s32_result, s32_lo, s32_hi, s32_ready); else n_pass++;
    run_op(0, FN_MFHI, 0, 0, r, h, l, dz, il, lat, er, eh, el, edz, eil, emc);
    n_checks++; if (r !== 32'd2) $display("FAIL mfhi got %0d exp 2", r); else n_pass++;
    run_op(0, FN_MFLO, 0, 0, r, h, l, dz, il, lat, er, eh, el, edz, eil, emc);
    n_checks++; if (r !== 32'd14) $display("FAIL mflo got %0d exp 14", r); else n_pass++;
  endtask

  task automatic test_multu_busy;
    logic got;
    int lat;
    longint unsigned mr;
    bit e1, e2, e3;
    ref_model(32, FN_MULTU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, m_hi32, m_lo32, mr, e1, e2, e3);
    @(negedge clk);
    s32_start = 1; s32_funct = FN_MULTU; s32_a = 32'hFFFF_FFFF; s32_b = 32'hFFFF_FFFF;
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      got = s32_valid;
      s32_funct = FN_ADD; s32_a = 32'd1; s32_b = 32'd1;
      s32_start = (lat < 30) && (lat % 5 == 2);
    end
    s32_start = 0;
    n_checks++; if (lat != 33) $display("FAIL multu_latency got %0d exp 33", lat); else n_pass++;
    n_checks++; if ({s32_hi, s32_lo, s32_result} !== {32'hFFFF_FFFE, 32'd1, 32'd1}) $display("FAIL multu_max got hi=%h lo=%h r=%h exp fffffffe 1 1", s32_hi, s32_lo, s32_result); else n_pass++;
    @(negedge clk);
    n_checks++; if (s32_valid !== 1'b0) $display("FAIL busy_start_ignored got valid=%b exp 0", s32_valid); else n_pass++;
  endtask

  task automatic test_div_zero(input bit n8);
    logic [31:0] r, h, l, er, eh, el, ones;
    logic dz, il;
    bit edz, eil, emc;
    int lat;
    ones = n8 ? 32'hFF : 32'hFFFF_FFFF;
    run_op(n8, FN_DIVU, n8 ? 32'h12 : 32'h1234, 32'd0, r, h, l, dz, il, lat, er, eh, el, edz, eil, emc);
    n_checks++; if ({lat == 1, dz, r, l, h} !== {2'b11, ones, ones, n8 ? 32'h12 : 32'h1234}) $display("FAIL div_zero w8=%b got lat=%0d dz=%b r=%h lo=%h hi=%h", n8, lat, dz, r, l, h); else n_pass++;
    n_checks++; if ((n8 ? s8_ready : s32_ready) !== 1'b1) $display("FAIL div_zero_ready w8=%b got 0 exp 1", n8); else n_pass++;
  endtask

  task automatic test_width8_directed;
    logic [31:0] r, h, l, er, eh, el;
    logic dz, il;
    bit edz, eil, emc;
    int lat;
    run_op(1, FN_ADD, 32'h7F, 32'h1, r, h, l, dz, il, lat, er, eh, el, edz, eil, emc);
    n_checks++; if (r !== 32'h80 || lat != 1) $display("FAIL add8 got r=%h lat=%0d exp 80 1", r, lat); else n_pass++;
    run_op(1, FN_SUB, 32'd5, 32'd7, r, h, l, dz, il, lat, er, eh, el, edz, eil, emc);
    n_checks++; if (r !== 32'hFE) $display("FAIL sub8 got %h exp fe", r); else n_pass++;
    run_op(1, FN_DIVU, 32'd100, 32'd7, r, h, l, dz, il, lat, er, eh, el, edz, eil, emc);
    n_checks++; if ({lat == 9, l, h} !== {1'b1, 32'd14, 32'd2}) $display("FAIL divu8 got lat=%0d lo=%0d hi=%0d exp 9 14 2", lat, l, h); else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] r, h, l, er, eh, el;
    logic dz, il;
    bit edz, eil, emc;
    int lat, spurious;
    @(negedge clk);
    s32_start = 1; s32_funct = FN_DIVU; s32_a = 32'd100; s32_b = 32'd7;
    @(negedge clk);
    s32_start = 0;
    repeat (9) @(negedge clk);
    reset = 1;
    #1;
    n_checks++; if ({s32_hi, s32_lo, s32_result, s32_valid} !== 97'h0) $display("FAIL reset_mid got hi=%h lo=%h r=%h v=%b exp 0", s32_hi, s32_lo, s32_result, s32_valid); else n_pass++;
    m_hi32 = 0; m_lo32 = 0; m_hi8 = 0; m_lo8 = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s32_valid) spurious++;
    end
    n_checks++; if (spurious != 0 || s32_ready !== 1'b1) $display("FAIL reset_abort got pulses=%0d ready=%b exp 0 1", spurious, s32_ready); else n_pass++;
    run_op(0, FN_ADD, 32'd2, 32'd3, r, h, l, dz, il, lat, er, eh, el, edz, eil, emc);
    n_checks++; if (r !== 32'd5) $display("FAIL add_after_reset got %0d exp 5", r); else n_pass++;
  endtask

  task automatic test_random(input bit n8, input int n);
    logic [5:0] ftab [12];
    logic [31:0] r, h, l, er, eh, el, a, b;
    logic dz, il;
    bit edz, eil, emc;
    int lat, exp_lat;
    logic [5:0] f;
    ftab = '{FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SLL, FN_SRL,
             FN_MFHI, FN_MFLO, FN_MULTU, FN_DIVU, 6'd63};
    for (int i = 0; i < n; i++) begin
      f = ftab[$urandom_range(0, 11)];
      if (f == 6'd63) f = 6'($urandom_range(44, 63));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (f == FN_DIVU && $urandom_range(0, 1) == 1) b = b & 32'hFF;
      run_op(n8, f, a, b, r, h, l, dz, il, lat, er, eh, el, edz, eil, emc);
      exp_lat = emc ? (n8 ? 9 : 33) : 1;
      n_checks++; if ({r, h, l, dz, il} !== {er, eh, el, edz, eil}) $display("FAIL rand w8=%b f=%0d a=%h b=%h got r=%h hi=%h lo=%h dz=%b il=%b exp r=%h hi=%h lo=%h dz=%b il=%b", n8, f, a, b, r, h, l, dz, il, er, eh, el, edz, eil); else n_pass++;
      n_checks++; if (lat != exp_lat) $display("FAIL rand_lat w8=%b f=%0d got %0d exp %0d", n8, f, lat, exp_lat); else n_pass++;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_single_ops();
    test_divu();
    test_multu_busy();
    test_div_zero(0);
    test_width8_directed();
    test_div_zero(1);
    test_random(0, 40);
    test_random(1, 30);
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
